// File: rtl/axi_burst_write_master.sv
// AXI4 write-only initiator: splits one (addr, len) command into 4KB-safe INCR bursts and collects B.
// Optional build macro AXI_WM_STATS_EN adds saturating AW/W stall-cycle counters.
module axi_burst_write_master #(
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int IDWidth        = 1,
    parameter int MaxBurstLen    = 16,
    parameter int MaxOutstanding = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AddressWidth-1:0]   cmd_addr,
    input  logic [15:0]               cmd_len,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DataWidth-1:0]      din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [AddressWidth-1:0]   awaddr,
    output logic [IDWidth-1:0]        awid,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DataWidth-1:0]      wdata,
    output logic [DataWidth/8-1:0]    wstrb,
    output logic [IDWidth-1:0]        wid,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [IDWidth-1:0]        bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
`ifdef AXI_WM_STATS_EN
    ,
    output logic [31:0]               stat_aw_stall,
    output logic [31:0]               stat_w_stall
`endif
);
    localparam int SZ = $clog2(DataWidth / 8);
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                  state_q;
    logic                    cmd_ready_q, busy_q, bready_q, done_q, err_q;
    logic                    awvalid_q;
    logic [AddressWidth-1:0] awaddr_q, addr_q;
    logic [7:0]              awlen_q;
    logic [8:0]              aw_beats_q;
    logic [15:0]             aw_rem_q, w_rem_q;
    logic                    w_act_q;
    logic [8:0]              w_cnt_q;
    logic [CW-1:0]           out_q, fifo_cnt_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [8:0]              fifo_q [MaxOutstanding];

    logic        aw_hs, w_hs, b_hs, aw_issue, fifo_pop;
    logic [12:0] bnd_beats;
    logic [15:0] beats_c;
    logic        unused_bid;

    assign unused_bid = ^bid;

    // Beats left before the next 4KB page; never zero because the address is beat-aligned.
    assign bnd_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> SZ;

    always_comb begin
        beats_c = aw_rem_q;
        if (beats_c > 16'(MaxBurstLen)) beats_c = 16'(MaxBurstLen);
        if (beats_c > 16'(bnd_beats))   beats_c = 16'(bnd_beats);
    end

    assign aw_hs    = awvalid_q && awready;
    assign w_hs     = din_valid && w_act_q && wready;
    assign b_hs     = bvalid && bready_q;
    assign aw_issue = (state_q == RUN) && !awvalid_q && (aw_rem_q != 16'd0)
                      && (out_q < CW'(MaxOutstanding));
    assign fifo_pop = !w_act_q && (fifo_cnt_q != '0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            aw_beats_q  <= '0;
            addr_q      <= '0;
            aw_rem_q    <= '0;
            w_rem_q     <= '0;
            w_act_q     <= 1'b0;
            w_cnt_q     <= '0;
            out_q       <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q      <= cmd_addr;
                    aw_rem_q    <= cmd_len;
                    w_rem_q     <= cmd_len;
                    err_q       <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    if (cmd_len == 16'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= RUN;
                        bready_q <= 1'b1;
                    end
                end
                RUN: if (aw_rem_q == 16'd0 && !awvalid_q && w_rem_q == 16'd0) state_q <= DRAIN;
                DRAIN: if (out_q == '0) begin
                    state_q  <= DONE;
                    done_q   <= 1'b1;
                    bready_q <= 1'b0;
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // AW payload is latched once and held until awready.
            if (aw_issue) begin
                awvalid_q  <= 1'b1;
                awaddr_q   <= addr_q;
                awlen_q    <= 8'(beats_c - 16'd1);
                aw_beats_q <= 9'(beats_c);
                addr_q     <= addr_q + (AddressWidth'(beats_c) << SZ);
                aw_rem_q   <= aw_rem_q - beats_c;
            end
            if (aw_hs) begin
                awvalid_q          <= 1'b0;
                fifo_q[wr_ptr_q]   <= aw_beats_q;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end

            // A burst becomes eligible for W only after its AW has been accepted.
            if (fifo_pop) begin
                w_act_q  <= 1'b1;
                w_cnt_q  <= fifo_q[rd_ptr_q];
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end else if (w_hs) begin
                w_cnt_q <= w_cnt_q - 9'd1;
                w_rem_q <= w_rem_q - 16'd1;
                if (w_cnt_q == 9'd1) w_act_q <= 1'b0;
            end

            case ({aw_hs, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            case ({aw_hs, b_hs})
                2'b10:   out_q <= out_q + CW'(1);
                2'b01:   out_q <= out_q - CW'(1);
                default: out_q <= out_q;
            endcase

            if (b_hs && bresp != 2'b00) err_q <= 1'b1;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bready    = bready_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign awlen     = awlen_q;
    assign awid      = '0;
    assign awsize    = 3'(SZ);
    assign awburst   = 2'b01;
    assign wid       = '0;
    assign wstrb     = '1;
    assign wdata     = din;
    assign wvalid    = din_valid && w_act_q;
    assign din_ready = wready && w_act_q;
    assign wlast     = w_act_q && (w_cnt_q == 9'd1);

`ifdef AXI_WM_STATS_EN
    logic [31:0] stat_aw_q, stat_w_q;

    always_ff @(posedge clk) begin
        if (reset || (cmd_valid && cmd_ready_q)) begin
            stat_aw_q <= '0;
            stat_w_q  <= '0;
        end else begin
            if (awvalid_q && !awready && stat_aw_q != '1) stat_aw_q <= stat_aw_q + 32'd1;
            if (wvalid && !wready && stat_w_q != '1)      stat_w_q  <= stat_w_q + 32'd1;
        end
    end

    assign stat_aw_stall = stat_aw_q;
    assign stat_w_stall  = stat_w_q;
`endif
endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: vector table of commands against a small AXI write-slave model.
module tb_axi_burst_write_master;
    localparam int          MAXO  = 4;
    localparam logic [31:0] DBASE = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0, din_ready;
    logic        done, err, busy;
    logic [31:0] awaddr;
    logic [0:0]  awid, wid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready = 1'b0;
    logic [0:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready;
`ifdef AXI_WM_STATS_EN
    logic [31:0] stat_aw_stall, stat_w_stall;
`endif

    always #5 clk = ~clk;

    axi_burst_write_master dut (
        .clk(clk), .reset(reset),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .done(done), .err(err), .busy(busy),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_WM_STATS_EN
        , .stat_aw_stall(stat_aw_stall), .stat_w_stall(stat_w_stall)
`endif
    );

    int total = 0, bad = 0, cyc = 0;

    // DUT outputs as seen just after the last negedge; stable until the next posedge.
    logic        s_awv, s_wv, s_wlast, s_br, s_dinr, s_done, s_err, s_busy, s_cmdr;
    logic [31:0] s_awaddr, s_wdata;
    logic [7:0]  s_awlen;

    logic [31:0] aq_addr[$];
    logic [7:0]  aq_len[$];
    int          bq[$];
    logic [31:0] mem [2048];
    int  n_aw, outst, max_out, n_cross, n_order, n_wlast, w_bidx, w_left;
    int  done_cnt, done_cyc, last_b_cyc, din_idx, din_total, slverr_idx;
    bit  w_act, stall;
    logic [31:0] w_addr, a0_addr, al_addr;
    int  a0_len, al_len;

    typedef struct {
        logic [31:0] addr; int len; bit stall; int slverr;
        int naw; logic [31:0] a0; int l0; logic [31:0] al; int ll; bit err;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        aq_addr.delete(); aq_len.delete(); bq.delete();
        n_aw = 0; outst = 0; max_out = 0; n_cross = 0; n_order = 0; n_wlast = 0;
        w_bidx = 0; w_left = 0; w_act = 0; done_cnt = 0; done_cyc = -1; last_b_cyc = -1;
        din_idx = 0; bvalid = 0; bresp = 2'b00; din_valid = 0;
        a0_addr = '0; al_addr = '0; a0_len = -1; al_len = -1;
        for (int k = 0; k < 2048; k++) mem[k] = 32'hDEAD_BEEF;
    endtask

    function automatic bit go();
        return !stall || ($urandom_range(0, 9) >= 3);
    endfunction

    // One clock: resolve handshakes from the previous posedge, drive slave/source, sample DUT.
    task automatic tick();
        @(negedge clk);
        if (reset) model_clear();
        else begin
            if (s_awv && awready) begin
                if (n_aw == 0) begin a0_addr = s_awaddr; a0_len = int'(s_awlen); end
                al_addr = s_awaddr; al_len = int'(s_awlen);
                if (int'(s_awaddr[11:0]) + (int'(s_awlen) + 1) * 4 > 4096) n_cross++;
                aq_addr.push_back(s_awaddr); aq_len.push_back(s_awlen);
                n_aw++; outst++;
                if (outst > max_out) max_out = outst;
            end
            if (s_wv && wready) begin
                if (!w_act) begin
                    if (aq_len.size() == 0) n_order++;
                    else begin
                        w_act = 1; w_addr = aq_addr.pop_front(); w_left = int'(aq_len.pop_front()) + 1;
                    end
                end
                if (w_act) begin
                    mem[int'((w_addr >> 2) & 32'h7FF)] = s_wdata;
                    w_addr += 4; w_left--;
                    if (s_wlast != (w_left == 0)) n_wlast++;
                    if (w_left == 0) begin w_act = 0; bq.push_back(w_bidx); w_bidx++; end
                end
            end
            if (din_valid && s_dinr) begin din_idx++; din_valid = 0; end
            if (bvalid && s_br) begin outst--; bvalid = 0; last_b_cyc = cyc; end
        end
        awready = go();
        wready  = go();
        if (!bvalid && bq.size() > 0 && go()) begin
            int id;
            id = bq.pop_front();
            bvalid = 1;
            bresp = (id == slverr_idx) ? 2'b10 : 2'b00;
        end
        if (!din_valid) din_valid = (din_idx < din_total) && go();
        din = DBASE + din_idx;
        #1;
        s_awv = awvalid; s_awaddr = awaddr; s_awlen = awlen; s_wv = wvalid; s_wdata = wdata;
        s_wlast = wlast; s_br = bready; s_dinr = din_ready; s_done = done; s_err = err;
        s_busy = busy; s_cmdr = cmd_ready;
        if (s_done) begin done_cnt++; done_cyc = cyc; end
        cyc++;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int l, output int acc);
        check("idle_cmd_ready", s_cmdr, 1);
        cmd_addr = a; cmd_len = 16'(l); cmd_valid = 1; din_total = l; acc = cyc;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
        check("done_seen", done_cnt != 0, 1);
        repeat (4) tick();
    endtask

    initial begin
        int acc, nbad;
        vecs[0] = '{32'h100,   4, 0, -1,  1, 32'h100,  3, 32'h100,  3, 0};
        vecs[1] = '{32'h0,    40, 0, -1,  3, 32'h0,   15, 32'h80,   7, 0};
        vecs[2] = '{32'hFF8,   4, 0, -1,  2, 32'hFF8,  1, 32'h1000, 1, 0};
        vecs[3] = '{32'hFC0,  20, 0, -1,  2, 32'hFC0, 15, 32'h1000, 3, 0};
        vecs[4] = '{32'h3000, 200, 1, -1, 13, 32'h3000, 15, 32'h3300, 7, 0};
        vecs[5] = '{32'h0,    40, 0,  1,  3, 32'h0,   15, 32'h80,   7, 1};
        vecs[6] = '{32'h7F0,   1, 0, -1,  1, 32'h7F0,  0, 32'h7F0,  0, 0};
        vecs[7] = '{32'h400,   0, 0, -1,  0, 32'h0,    0, 32'h0,    0, 0};

        stall = 0; slverr_idx = -1; din_total = 1;
        repeat (3) tick();
        check("rst_awvalid", s_awv, 0);
        check("rst_wvalid", s_wv, 0);
        check("rst_din_ready", s_dinr, 0);
        check("rst_bready", s_br, 0);
        check("rst_done", s_done, 0);
        check("rst_err", s_err, 0);
        check("rst_busy", s_busy, 0);
        check("rst_cmd_ready", s_cmdr, 1);
        reset = 0;
        tick();

        for (int v = 0; v < 8; v++) begin
            model_clear();
            stall = vecs[v].stall; slverr_idx = vecs[v].slverr;
            run_cmd(vecs[v].addr, vecs[v].len, acc);
            check($sformatf("v%0d_n_aw", v), n_aw, vecs[v].naw);
            if (vecs[v].naw > 0) begin
                check($sformatf("v%0d_aw0_addr", v), a0_addr, vecs[v].a0);
                check($sformatf("v%0d_aw0_len", v), a0_len, vecs[v].l0);
                check($sformatf("v%0d_awN_addr", v), al_addr, vecs[v].al);
                check($sformatf("v%0d_awN_len", v), al_len, vecs[v].ll);
                check($sformatf("v%0d_done_after_lastB", v), done_cyc - last_b_cyc, 1);
            end else begin
                check($sformatf("v%0d_done_latency", v), done_cyc, acc);
            end
            nbad = 0;
            for (int k = 0; k < vecs[v].len; k++)
                if (mem[int'(((vecs[v].addr >> 2) + k) & 32'h7FF)] !== DBASE + k) nbad++;
            check($sformatf("v%0d_data_errs", v), nbad, 0);
            check($sformatf("v%0d_4k_cross", v), n_cross, 0);
            check($sformatf("v%0d_w_before_aw", v), n_order, 0);
            check($sformatf("v%0d_wlast_errs", v), n_wlast, 0);
            check($sformatf("v%0d_outstanding_over", v), max_out > MAXO, 0);
            check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("v%0d_err", v), s_err, vecs[v].err);
            check($sformatf("v%0d_idle_busy", v), s_busy, 0);
        end

        // Reset in the middle of a long command, then a zero-length command.
        model_clear();
        stall = 0; slverr_idx = -1;
        check("mid_idle_cmd_ready", s_cmdr, 1);
        cmd_addr = 32'h0; cmd_len = 16'd200; cmd_valid = 1; din_total = 200;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 200 && n_aw < 2; i++) tick();
        check("mid_second_aw_seen", n_aw >= 2, 1);
        tick();
        check("mid_busy_before_rst", s_busy, 1);
        reset = 1;
        tick();
        check("mid_rst_awvalid", s_awv, 0);
        check("mid_rst_wvalid", s_wv, 0);
        check("mid_rst_bready", s_br, 0);
        check("mid_rst_cmd_ready", s_cmdr, 1);
        check("mid_rst_busy", s_busy, 0);
        reset = 0; din_total = 0;
        repeat (3) tick();
        check("mid_no_done_after_rst", done_cnt, 0);
        run_cmd(32'h0, 0, acc);
        check("mid_len0_done_latency", done_cyc, acc);
        check("mid_len0_done_pulses", done_cnt, 1);
        check("mid_len0_n_aw", n_aw, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
